ram_sp_sync: RTL and testbench
==============================

Name: ram_sp_sync

Overview:
- Single-port synchronous RAM, default 64 words x 8 bits.
- One address bus is shared by reads and writes. Reads are registered with one-cycle latency.
- Used as a small general-purpose scratch memory inside the datapath.
- Asynchronous active-low reset clears the output register and all storage locations.

Parameters:
- DATA_WIDTH, 8, width of each word and of the data buses.
- ADDR_WIDTH, 6, width of the address bus.
- DEPTH, 64, number of words. Must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- write_en  input  1  1 = write cycle, 0 = read cycle.
- address  input  ADDR_WIDTH  word address for the read or the write.
- data_in  input  DATA_WIDTH  write data, sampled when write_en=1.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- One clock (clk) and one reset (rst_n); reset is asynchronous and active-low.
- Reset (rst_n=0):
  - Immediately, without waiting for a clock edge, data_out=0 and every memory word=0.
  - Holds while rst_n is low; clock edges during reset have no effect.
  - Leaving reset is synchronous-safe: the first rising edge with rst_n=1 is a normal cycle.
- Write cycle, rising edge with write_en=1 and address<DEPTH:
  - mem[address] <= data_in.
  - data_out <= data_in (write-through: output shows the newly written word next cycle).
- Read cycle, rising edge with write_en=0 and address<DEPTH:
  - data_out <= mem[address]. Value is visible after the edge (latency 1 cycle).
  - Memory contents are unchanged.
- Out-of-range address (address>=DEPTH, only possible when DEPTH<2**ADDR_WIDTH):
  - A write is ignored; no memory word changes, and data_out <= 0.
  - A read gives data_out <= 0.
  - No wrap-around or aliasing.
- Inputs are sampled only at the rising edge. Changes between edges never affect memory or data_out.
- Back-to-back accesses:
  - Every cycle is independent, with no bubbles.
  - A read immediately after a write to the same address returns the new data.
  - A write on every cycle updates data_out on every cycle.
- Reset asserted mid-operation: an in-flight write not yet clocked is lost, and all contents become 0.
- No X propagation: after reset, every readable location returns a defined value.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release, then read addresses 0, 1, 63 -> data_out=0 for each, one cycle after each read edge.
- Write/read: write 10@0, 20@1, 30@2 on consecutive edges, then read 0, 1, 2 on consecutive edges -> data_out=10, 20, 30, each one cycle after its read edge. Memory is unchanged by the reads.
- Write-through and overwrite:
  - Write 8'hA5@5 -> data_out=A5 after that edge.
  - Write 8'h3C@5, then read 5 -> data_out=3C.
  - Read 6 (never written) -> 0.
- Boundary addresses:
  - Write FF@63 and 01@0, then read 63 and 0 -> FF, 01.
  - With DEPTH=48, write 77@50, then read 50 -> 0. Read 2 (50 mod 48) -> still 0, confirming no aliasing.
- Async reset mid-stream: after writing 10@0, pull rst_n low between edges -> data_out goes to 0 at once, without a clock edge. Release, then read 0 -> 0.
- Input glitch: change address and data_in between edges while write_en=0 -> data_out changes only at edges, and memory is unchanged.

Source files
------------

// File: rtl/ram_sp_sync_if.sv
// ram_sp_sync_if: bus bundle for the single-port synchronous RAM.
//   write_en  : 1 = write cycle, 0 = read cycle
//   address   : word address shared by reads and writes
//   data_in   : write data
//   data_out  : registered read / write-through data
// master drives the request side; slave is the RAM.
interface ram_sp_sync_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output write_en,
    output address,
    output data_in,
    input  data_out
  );

  modport slave (
    input  write_en,
    input  address,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/ram_sp_sync.sv
// ram_sp_sync: single-port synchronous scratch RAM, DEPTH words of DATA_WIDTH.
//   clk   : clock, all updates on the rising edge
//   rst_n : asynchronous active-low reset; clears data_out and every word
//   bus   : ram_sp_sync_if.slave (write_en, address, data_in, data_out)
// Reads have one cycle of latency. Writes are written through to data_out.
// Addresses at or above DEPTH never touch storage and return zero.
module ram_sp_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_sp_sync_if.slave       bus
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_q;
  logic                  in_range;

  assign in_range     = ({1'b0, bus.address} < DEPTH_L);
  assign bus.data_out = data_q;

  // Storage is built from resettable flops so a reset clears every word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.write_en && in_range) begin
      mem[bus.address] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (!in_range) begin
      data_q <= '0;
    end else if (bus.write_en) begin
      data_q <= bus.data_in;
    end else begin
      data_q <= mem[bus.address];
    end
  end

endmodule

// File: tb/tb_ram_sp_sync.sv
// tb_ram_sp_sync: directed bench for ram_sp_sync. Instance a uses the default
// 64-word geometry; instance b uses DEPTH=48 to exercise out-of-range addresses.
module tb_ram_sp_sync;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  ram_sp_sync_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) ia ();
  ram_sp_sync_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) ib ();

  ram_sp_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  ram_sp_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(48)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one access on the selected instance (0 = a, 1 = b), the other idles
  // on a read of address 0, then step past the rising edge.
  task automatic step(input bit sel, input logic we, input logic [5:0] addr, input logic [7:0] din);
    if (!sel) begin
      ia.write_en = we; ia.address = addr; ia.data_in = din;
      ib.write_en = 1'b0; ib.address = 6'd0; ib.data_in = 8'h00;
    end else begin
      ib.write_en = we; ib.address = addr; ib.data_in = din;
      ia.write_en = 1'b0; ia.address = 6'd0; ia.data_in = 8'h00;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    // Reset held for two edges while a write is being presented.
    rst_n = 1'b0;
    ia.write_en = 1'b1; ia.address = 6'd0; ia.data_in = 8'hEE;
    ib.write_en = 1'b1; ib.address = 6'd0; ib.data_in = 8'hEE;
    @(posedge clk); @(posedge clk); #1;
    check("reset_out_a", ia.data_out, 8'h00);
    check("reset_out_b", ib.data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 1'b0, 6'd0,  8'h00); check("rst_rd0",  ia.data_out, 8'h00);
    step(0, 1'b0, 6'd1,  8'h00); check("rst_rd1",  ia.data_out, 8'h00);
    step(0, 1'b0, 6'd63, 8'h00); check("rst_rd63", ia.data_out, 8'h00);

    // Consecutive writes, then consecutive reads.
    step(0, 1'b1, 6'd0, 8'd10); check("wr0_thru", ia.data_out, 8'd10);
    step(0, 1'b1, 6'd1, 8'd20); check("wr1_thru", ia.data_out, 8'd20);
    step(0, 1'b1, 6'd2, 8'd30); check("wr2_thru", ia.data_out, 8'd30);
    step(0, 1'b0, 6'd0, 8'h00); check("rd0", ia.data_out, 8'd10);
    step(0, 1'b0, 6'd1, 8'h00); check("rd1", ia.data_out, 8'd20);
    step(0, 1'b0, 6'd2, 8'h00); check("rd2", ia.data_out, 8'd30);
    step(0, 1'b0, 6'd0, 8'h00); check("rd0_again", ia.data_out, 8'd10);

    // Write-through and overwrite.
    step(0, 1'b1, 6'd5, 8'hA5); check("wr5_thru",   ia.data_out, 8'hA5);
    step(0, 1'b1, 6'd5, 8'h3C); check("ovr5_thru",  ia.data_out, 8'h3C);
    step(0, 1'b0, 6'd5, 8'h00); check("rd5_ovr",    ia.data_out, 8'h3C);
    step(0, 1'b0, 6'd6, 8'h00); check("rd6_unwrit", ia.data_out, 8'h00);

    // Boundary addresses on the full-depth instance.
    step(0, 1'b1, 6'd63, 8'hFF); check("wr63_thru", ia.data_out, 8'hFF);
    step(0, 1'b1, 6'd0,  8'h01); check("wr0b_thru", ia.data_out, 8'h01);
    step(0, 1'b0, 6'd63, 8'h00); check("rd63", ia.data_out, 8'hFF);
    step(0, 1'b0, 6'd0,  8'h00); check("rd0b", ia.data_out, 8'h01);

    // DEPTH=48 instance: last valid word, then out-of-range write and reads.
    step(1, 1'b1, 6'd47, 8'h55); check("b_wr47_thru", ib.data_out, 8'h55);
    step(1, 1'b1, 6'd50, 8'h77); check("b_wr50_oor",  ib.data_out, 8'h00);
    step(1, 1'b0, 6'd47, 8'h00); check("b_rd47",      ib.data_out, 8'h55);
    step(1, 1'b0, 6'd50, 8'h00); check("b_rd50_oor",  ib.data_out, 8'h00);
    step(1, 1'b0, 6'd2,  8'h00); check("b_rd2_alias", ib.data_out, 8'h00);

    // Input glitches between edges while reading.
    step(0, 1'b0, 6'd0, 8'h00); check("glitch_pre", ia.data_out, 8'h01);
    ia.address = 6'd63; ia.data_in = 8'h99;
    #1;
    ia.write_en = 1'b1;
    #1;
    ia.write_en = 1'b0; ia.address = 6'd5; ia.data_in = 8'h42;
    #1;
    check("glitch_hold", ia.data_out, 8'h01);
    step(0, 1'b0, 6'd63, 8'h00); check("glitch_rd63", ia.data_out, 8'hFF);
    step(0, 1'b0, 6'd5,  8'h00); check("glitch_rd5",  ia.data_out, 8'h3C);

    // Asynchronous reset in mid-stream, with a pending write lost.
    step(0, 1'b1, 6'd0, 8'd10); check("mid_wr0", ia.data_out, 8'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", ia.data_out, 8'h00);
    check("async_rst_b", ib.data_out, 8'h00);
    ia.write_en = 1'b1; ia.address = 6'd3; ia.data_in = 8'h99;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b0, 6'd0,  8'h00); check("post_rst_rd0",  ia.data_out, 8'h00);
    step(0, 1'b0, 6'd3,  8'h00); check("post_rst_rd3",  ia.data_out, 8'h00);
    step(0, 1'b0, 6'd63, 8'h00); check("post_rst_rd63", ia.data_out, 8'h00);
    step(1, 1'b0, 6'd47, 8'h00); check("post_rst_b47",  ib.data_out, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
